// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and helpers for register-style slaves.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  // Number of byte-offset address bits below the word index.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_wr_join.sv
// AXI4-Lite write-channel join: holds AW and W independently and emits a
// single-cycle commit strobe on the first edge where both are available.
module axil_wr_join #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic                    bvalid,
  output logic                    commit,
  output logic [ADDR_WIDTH-1:0]   cm_addr,
  output logic [DATA_WIDTH-1:0]   cm_data,
  output logic [DATA_WIDTH/8-1:0] cm_strb
);

  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    aw_hs, w_hs;

  // Readies drop while a response is pending so at most one write is in flight;
  // gated by reset so every output reads 0 while reset is asserted.
  assign awready = !rst && !aw_held_q && !bvalid;
  assign wready  = !rst && !w_held_q && !bvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Commit as soon as both halves exist, taking live bus values when not held.
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign cm_addr = aw_held_q ? awaddr_q : awaddr;
  assign cm_data = w_held_q ? wdata_q : wdata;
  assign cm_strb = w_held_q ? wstrb_q : wstrb;

  // Next-state for the holding registers.
  always_comb begin
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_held_d = aw_held_q || aw_hs;
    w_held_d  = w_held_q || w_hs;
    if (aw_hs) awaddr_d = awaddr;
    if (w_hs) begin
      wdata_d = wdata;
      wstrb_d = wstrb;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  // Holding-register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite register file: RW control registers with byte strobes and write
// pulses, RO registers sourced from status_in, DECERR beyond NUM_REGS.
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int                DATA_WIDTH = 32,
  parameter int                ADDR_WIDTH = 8,
  parameter int                NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                           s1_axi_aclk,
  input  logic                           s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]          s1_axi_awaddr,
  input  logic                           s1_axi_awvalid,
  output logic                           s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s1_axi_wstrb,
  input  logic                           s1_axi_wvalid,
  output logic                           s1_axi_wready,
  output logic [1:0]                     s1_axi_bresp,
  output logic                           s1_axi_bvalid,
  input  logic                           s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s1_axi_araddr,
  input  logic                           s1_axi_arvalid,
  output logic                           s1_axi_arready,
  output logic [DATA_WIDTH-1:0]          s1_axi_rdata,
  output logic [1:0]                     s1_axi_rresp,
  output logic                           s1_axi_rvalid,
  input  logic                           s1_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int STRB_W   = DATA_WIDTH / 8;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 pulse_q, pulse_d;
  logic                                bvalid_q, bvalid_d;
  axi_resp_t                           bresp_q, bresp_d;
  logic                                rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]               rdata_q, rdata_d;
  axi_resp_t                           rresp_q, rresp_d;

  logic                  commit;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [STRB_W-1:0]     cm_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  ar_hs;
  logic                  unused_addr_lsbs;

  axil_wr_join #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_join (
    .clk     (s1_axi_aclk),
    .rst     (s1_axi_areset),
    .awaddr  (s1_axi_awaddr),
    .awvalid (s1_axi_awvalid),
    .awready (s1_axi_awready),
    .wdata   (s1_axi_wdata),
    .wstrb   (s1_axi_wstrb),
    .wvalid  (s1_axi_wvalid),
    .wready  (s1_axi_wready),
    .bvalid  (bvalid_q),
    .commit  (commit),
    .cm_addr (cm_addr),
    .cm_data (cm_data),
    .cm_strb (cm_strb)
  );

  assign wr_idx           = cm_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx           = s1_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign unused_addr_lsbs = ^{cm_addr[ADDR_LSB-1:0], s1_axi_araddr[ADDR_LSB-1:0]};

  assign s1_axi_arready = !s1_axi_areset && !rvalid_q;
  assign ar_hs          = s1_axi_arvalid && s1_axi_arready;

  assign s1_axi_bvalid = bvalid_q;
  assign s1_axi_bresp  = bresp_q;
  assign s1_axi_rvalid = rvalid_q;
  assign s1_axi_rdata  = rdata_q;
  assign s1_axi_rresp  = rresp_q;
  assign reg_out       = regs_q;
  assign reg_wr_pulse  = pulse_q;

  // Write commit: decode, strobed byte update, pulse and B response.
  always_comb begin
    regs_d   = regs_q;
    pulse_d  = '0;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && s1_axi_bready) bvalid_d = 1'b0;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = DECERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (32'(wr_idx) == i) begin
          if (RO_MASK[i]) begin
            bresp_d = SLVERR;
          end else begin
            bresp_d    = OKAY;
            pulse_d[i] = 1'b1;
            for (int b = 0; b < STRB_W; b++)
              if (cm_strb[b]) regs_d[i][b*8 +: 8] = cm_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read: mux from pre-commit register values (read-old) or live status.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s1_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = DECERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (32'(rd_idx) == i) begin
          rresp_d = OKAY;
          rdata_d = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
        end
      end
    end
  end

  // Register file and response channel state.
  always_ff @(posedge s1_axi_aclk or posedge s1_axi_areset) begin
    if (s1_axi_areset) begin
      regs_q   <= '0;
      pulse_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      regs_q   <= regs_d;
      pulse_q  <= pulse_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule

// File: doc/axil_regfile_slave.md
Name: axil_regfile_slave

Overview:
- Parametrised AXI4-Lite slave holding NUM_REGS word-wide registers. Each register is either read/write control or read-only status.
- Sits on the s1 AXI-Lite bus. Exposes control registers to user logic and returns status words from hardware.
- Adds byte-strobed writes, decoupled AW/W acceptance, 2-bit OKAY/SLVERR/DECERR responses and per-register write pulses.

Parameters:
- DATA_WIDTH, 32, data bus width; must be 32 or 64.
- ADDR_WIDTH, 8, byte address width.
- NUM_REGS, 16, number of registers; must be <= 2**(ADDR_WIDTH-ADDR_LSB).
- RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only, sourced from status_in.

Ports:
- s1_axi_aclk  in  1  clock.
- s1_axi_areset  in  1  reset; one clock; asynchronous, active-high.
- s1_axi_awaddr  in  ADDR_WIDTH  write address.
- s1_axi_awvalid  in  1; s1_axi_awready  out  1.
- s1_axi_wdata  in  DATA_WIDTH; s1_axi_wstrb  in  DATA_WIDTH/8  byte enables.
- s1_axi_wvalid  in  1; s1_axi_wready  out  1.
- s1_axi_bresp  out  2; s1_axi_bvalid  out  1; s1_axi_bready  in  1.
- s1_axi_araddr  in  ADDR_WIDTH; s1_axi_arvalid  in  1; s1_axi_arready  out  1.
- s1_axi_rdata  out  DATA_WIDTH; s1_axi_rresp  out  2; s1_axi_rvalid  out  1; s1_axi_rready  in  1.
- reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- status_in  in  NUM_REGS*DATA_WIDTH  status words; only RO slices are used.
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe when a register is written.

Behaviour:
- Reset (async assert, sync release): all outputs 0; all registers 0; aw_held/w_held cleared. A transaction in flight at reset is dropped and no response is issued.
- Decode: ADDR_LSB = log2(DATA_WIDTH/8). idx = addr[ADDR_WIDTH-1:ADDR_LSB]. Address low bits are ignored.
  - idx >= NUM_REGS -> DECERR (2'b11).
- Write path: AW and W are accepted independently.
  - awready = !aw_held && !bvalid. wready = !w_held && !bvalid.
  - A handshake latches the address or data+strb into a holding register.
  - Commit edge: first edge at which both are available (held, or handshaking this cycle).
- At the commit edge:
  - If idx is in range and RO_MASK[idx]=0: write the bytes enabled by wstrb, pulse reg_wr_pulse[idx] for exactly one cycle, bresp=OKAY.
  - RO register: no write, no pulse, bresp=SLVERR (2'b10).
  - Out of range: bresp=DECERR.
  - In all cases bvalid=1 next cycle and held flags are cleared.
- Write latency: AW+W handshaking in the same cycle N -> bvalid in N+1. AW in N, W in N+k -> bvalid in N+k+1.
- wstrb=0 on a valid RW register: no data change, pulse still fires, OKAY.
- bvalid stays high with bresp stable until bready; it clears on the bvalid&&bready edge. awready/wready rise the following cycle.
- Read path: arready = !rvalid.
  - On an AR handshake in cycle N: rdata/rresp are registered and rvalid=1 in N+1.
  - RW register: returns the register value before any write committing at the same edge (read-old).
  - RO register: returns status_in slice sampled at the handshake edge; OKAY.
  - Out of range: rdata=0, rresp=DECERR.
- rvalid/rdata/rresp are held stable until rready; rvalid clears on the handshake edge.
- Read and write paths are fully independent; simultaneous AR and write commit are both served in the same cycle.
- Max throughput: one write per 2 cycles, one read per 2 cycles.

Decomposition:
- Package axil_pkg:
  - typedef enum logic [1:0] axi_resp_t {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}.
  - Function clog2-based addr_lsb(DATA_WIDTH).
- Sub-module axil_wr_join: AW/W holding registers, ready generation and commit strobe. Reused by future AXI-Lite slaves.
- Register array, decode and read mux stay in axil_regfile_slave.

Test Plan:
- Reset, then AW=0x04 and W=0xDEADBEEF with strb=4'hF in the same cycle -> bvalid next cycle, bresp=00, reg_wr_pulse[1] one cycle. Read 0x04 -> rdata=0xDEADBEEF, rresp=00.
- W (0x000000AA, strb=4'h1) to addr 0x08, AW three cycles later -> bvalid one cycle after AW; reg2=0x000000AA with upper bytes unchanged. Second W before bready is held off (wready=0).
- RO_MASK bit 3 set, status_in slice3=0x12345678: write 0x0C -> bresp=10, no pulse. Read 0x0C -> 0x12345678, rresp=00.
- Read 0xFC with NUM_REGS=16 -> rdata=0, rresp=11. Write there -> bresp=11, no register changes.
- Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid and their data stay stable; awready/wready/arready stay 0.
- Assert s1_axi_areset mid-transaction, after AW only (before W) -> all outputs 0 immediately. After release, a fresh AW+W completes normally with a single bvalid.
